// File: rtl/vga_pkg.sv
// Shared VGA 640x480 timing defaults, derived totals and sync windows.
// Imported by the scan driver and the colour mapper.
package vga_pkg;

  localparam int H_VISIBLE_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_VISIBLE_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  function automatic int span_total(input int vis, input int front, input int sync, input int back);
    return vis + front + sync + back;
  endfunction

  function automatic int sync_first(input int vis, input int front);
    return vis + front;
  endfunction

  function automatic int sync_last(input int vis, input int front, input int sync);
    return vis + front + sync - 1;
  endfunction

  function automatic logic in_window(input logic [9:0] cnt, input logic [9:0] lo, input logic [9:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

  localparam int H_TOTAL      = span_total(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL      = span_total(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF, V_BACK_DEF);
  localparam int H_SYNC_FIRST = sync_first(H_VISIBLE_DEF, H_FRONT_DEF);
  localparam int H_SYNC_LAST  = sync_last(H_VISIBLE_DEF, H_FRONT_DEF, H_SYNC_DEF);
  localparam int V_SYNC_FIRST = sync_first(V_VISIBLE_DEF, V_FRONT_DEF);
  localparam int V_SYNC_LAST  = sync_last(V_VISIBLE_DEF, V_FRONT_DEF, V_SYNC_DEF);

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic visible;
  } vga_ctrl_t;

  localparam vga_ctrl_t CTRL_IDLE = '{hsync: 1'b1, vsync: 1'b1, visible: 1'b0};

endpackage

// File: rtl/vga_delay_line.sv
// Enable-gated shift register with a loadable reset value; output is the last stage.
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             en,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_r [DEPTH];

  // Shift stages on each enable; reset forces every stage to the idle value
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) stage_r[i] <= rst_val;
    end else if (en) begin
      stage_r[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
    end
  end

  assign q = stage_r[DEPTH-1];

endmodule

// File: rtl/vga_scan_driver.sv
// VGA raster scan: pixel/line counters, delayed sync/blank generation and
// registered colour output, all advancing on the pixel-rate strobe.
module vga_scan_driver
  import vga_pkg::*;
#(
  parameter int H_VISIBLE  = H_VISIBLE_DEF,
  parameter int H_FRONT    = H_FRONT_DEF,
  parameter int H_SYNC     = H_SYNC_DEF,
  parameter int H_BACK     = H_BACK_DEF,
  parameter int V_VISIBLE  = V_VISIBLE_DEF,
  parameter int V_FRONT    = V_FRONT_DEF,
  parameter int V_SYNC     = V_SYNC_DEF,
  parameter int V_BACK     = V_BACK_DEF,
  parameter int PIPE_DELAY = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       pixel_en,
  input  logic [7:0] mapper_R,
  input  logic [7:0] mapper_G,
  input  logic [7:0] mapper_B,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic       VGA_BLANK_N,
  output logic       VGA_SYNC_N,
  output logic [7:0] VGA_R,
  output logic [7:0] VGA_G,
  output logic [7:0] VGA_B
);

  localparam logic [9:0] H_LAST   = 10'(span_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK) - 1);
  localparam logic [9:0] V_LAST   = 10'(span_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK) - 1);
  localparam logic [9:0] HS_FIRST = 10'(sync_first(H_VISIBLE, H_FRONT));
  localparam logic [9:0] HS_LAST  = 10'(sync_last(H_VISIBLE, H_FRONT, H_SYNC));
  localparam logic [9:0] VS_FIRST = 10'(sync_first(V_VISIBLE, V_FRONT));
  localparam logic [9:0] VS_LAST  = 10'(sync_last(V_VISIBLE, V_FRONT, V_SYNC));
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);

  logic [9:0] h_cnt_r, v_cnt_r, h_cnt_nxt_s, v_cnt_nxt_s;
  logic       frame_wrap_s;
  logic       frame_start_r;
  logic [7:0] r_r, g_r, b_r;
  vga_ctrl_t  raw_s, dly_s;

  // Next raster position; frame_wrap_s marks the corner (last pixel of last line)
  always_comb begin
    h_cnt_nxt_s  = h_cnt_r;
    v_cnt_nxt_s  = v_cnt_r;
    frame_wrap_s = 1'b0;
    if (h_cnt_r == H_LAST) begin
      h_cnt_nxt_s = 10'd0;
      if (v_cnt_r == V_LAST) begin
        v_cnt_nxt_s  = 10'd0;
        frame_wrap_s = 1'b1;
      end else begin
        v_cnt_nxt_s = v_cnt_r + 10'd1;
      end
    end else begin
      h_cnt_nxt_s = h_cnt_r + 10'd1;
    end
  end

  // Raster counters and the one-Clk frame pulse (not gated by the hold)
  always_ff @(posedge Clk) begin
    if (Reset) begin
      h_cnt_r       <= 10'd0;
      v_cnt_r       <= 10'd0;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= pixel_en & frame_wrap_s;
      if (pixel_en) begin
        h_cnt_r <= h_cnt_nxt_s;
        v_cnt_r <= v_cnt_nxt_s;
      end
    end
  end

  // Raw sync/visible decode of the current position
  always_comb begin
    raw_s         = CTRL_IDLE;
    raw_s.hsync   = ~in_window(h_cnt_r, HS_FIRST, HS_LAST);
    raw_s.vsync   = ~in_window(v_cnt_r, VS_FIRST, VS_LAST);
    raw_s.visible = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);
  end

  vga_delay_line #(
    .WIDTH($bits(vga_ctrl_t)),
    .DEPTH(PIPE_DELAY)
  ) u_ctrl_dly (
    .Clk     (Clk),
    .Reset   (Reset),
    .en      (pixel_en),
    .rst_val (CTRL_IDLE),
    .d       (raw_s),
    .q       (dly_s)
  );

  // Colour register: mapper value is only passed while the delayed pixel is visible
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_r <= 8'h00;
      g_r <= 8'h00;
      b_r <= 8'h00;
    end else if (pixel_en) begin
      r_r <= dly_s.visible ? mapper_R : 8'h00;
      g_r <= dly_s.visible ? mapper_G : 8'h00;
      b_r <= dly_s.visible ? mapper_B : 8'h00;
    end
  end

  assign DrawX       = h_cnt_r;
  assign DrawY       = v_cnt_r;
  assign frame_start = frame_start_r;
  assign VGA_HS      = dly_s.hsync;
  assign VGA_VS      = dly_s.vsync;
  assign VGA_BLANK_N = dly_s.visible;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_R       = r_r;
  assign VGA_G       = g_r;
  assign VGA_B       = b_r;

endmodule

// File: tb/tb_vga_scan_driver.sv
// Bench for vga_scan_driver: two reduced-geometry instances (PIPE_DELAY 1 and 2) and one
// default-geometry instance, checked against a strobe-count raster model.
module tb_vga_scan_driver;

  typedef struct packed {
    int hv; int hf; int hs; int hb;
    int vv; int vf; int vs; int vb;
    int pd;
  } geo_t;

  localparam geo_t G1 = '{20, 3, 5, 4, 6, 2, 2, 3, 1};
  localparam geo_t G2 = '{20, 3, 5, 4, 6, 2, 2, 3, 2};
  localparam geo_t G3 = '{640, 16, 96, 48, 480, 10, 2, 33, 1};
  localparam int HT1 = G1.hv + G1.hf + G1.hs + G1.hb;
  localparam int VT1 = G1.vv + G1.vf + G1.vs + G1.vb;
  localparam int FR1 = HT1 * VT1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        pixel_en = 1'b0;
  logic [23:0] mp [3];
  logic [9:0]  dx [3];
  logic [9:0]  dy [3];
  logic        fs [3];
  logic        hs [3];
  logic        vs [3];
  logic        bl [3];
  logic        sn [3];
  logic [7:0]  rr [3];
  logic [7:0]  gg [3];
  logic [7:0]  bb [3];
  logic [48:0] obs [3];
  logic [146:0] obs_all;

  int          n = 0;
  bit          just = 1'b0;
  int          clk_cnt = 0;
  logic [7:0]  seed;
  int          checks = 0;
  int          errors = 0;

  always #5 Clk = ~Clk;

  vga_scan_driver #(
    .H_VISIBLE(G1.hv), .H_FRONT(G1.hf), .H_SYNC(G1.hs), .H_BACK(G1.hb),
    .V_VISIBLE(G1.vv), .V_FRONT(G1.vf), .V_SYNC(G1.vs), .V_BACK(G1.vb),
    .PIPE_DELAY(G1.pd)
  ) dut1 (
    .Clk(Clk), .Reset(Reset), .pixel_en(pixel_en),
    .mapper_R(mp[0][23:16]), .mapper_G(mp[0][15:8]), .mapper_B(mp[0][7:0]),
    .DrawX(dx[0]), .DrawY(dy[0]), .frame_start(fs[0]),
    .VGA_HS(hs[0]), .VGA_VS(vs[0]), .VGA_BLANK_N(bl[0]), .VGA_SYNC_N(sn[0]),
    .VGA_R(rr[0]), .VGA_G(gg[0]), .VGA_B(bb[0])
  );

  vga_scan_driver #(
    .H_VISIBLE(G2.hv), .H_FRONT(G2.hf), .H_SYNC(G2.hs), .H_BACK(G2.hb),
    .V_VISIBLE(G2.vv), .V_FRONT(G2.vf), .V_SYNC(G2.vs), .V_BACK(G2.vb),
    .PIPE_DELAY(G2.pd)
  ) dut2 (
    .Clk(Clk), .Reset(Reset), .pixel_en(pixel_en),
    .mapper_R(mp[1][23:16]), .mapper_G(mp[1][15:8]), .mapper_B(mp[1][7:0]),
    .DrawX(dx[1]), .DrawY(dy[1]), .frame_start(fs[1]),
    .VGA_HS(hs[1]), .VGA_VS(vs[1]), .VGA_BLANK_N(bl[1]), .VGA_SYNC_N(sn[1]),
    .VGA_R(rr[1]), .VGA_G(gg[1]), .VGA_B(bb[1])
  );

  vga_scan_driver dut3 (
    .Clk(Clk), .Reset(Reset), .pixel_en(pixel_en),
    .mapper_R(mp[2][23:16]), .mapper_G(mp[2][15:8]), .mapper_B(mp[2][7:0]),
    .DrawX(dx[2]), .DrawY(dy[2]), .frame_start(fs[2]),
    .VGA_HS(hs[2]), .VGA_VS(vs[2]), .VGA_BLANK_N(bl[2]), .VGA_SYNC_N(sn[2]),
    .VGA_R(rr[2]), .VGA_G(gg[2]), .VGA_B(bb[2])
  );

  for (genvar i = 0; i < 3; i++) begin : g_obs
    assign obs[i] = {sn[i], dx[i], dy[i], fs[i], hs[i], vs[i], bl[i], rr[i], gg[i], bb[i]};
  end
  assign obs_all = {obs[0], obs[1], obs[2]};

  function automatic logic [23:0] colour(input int x, input int y, input logic [7:0] sd);
    logic [7:0] xb, yb;
    xb = x[7:0];
    yb = y[7:0];
    return {xb, yb, xb ^ yb ^ sd};
  endfunction

  // Colour the mapper presents now: that of the pixel shown pd strobes ago
  function automatic logic [23:0] mapper_val(input geo_t g, input int cnt, input logic [7:0] sd);
    int ht, fr, m, p;
    ht = g.hv + g.hf + g.hs + g.hb;
    fr = ht * (g.vv + g.vf + g.vs + g.vb);
    m  = cnt - g.pd;
    if (m < 0) return 24'h0;
    p = m % fr;
    return colour(p % ht, p / ht, sd);
  endfunction

  // Expected outputs after cnt strobes since reset
  function automatic logic [48:0] model(input geo_t g, input int cnt, input bit jst, input logic [7:0] sd);
    int ht, fr, p, x, y, m, k, px, py;
    logic e_fs, e_hs, e_vs, e_bl;
    logic [23:0] rgb;
    ht = g.hv + g.hf + g.hs + g.hb;
    fr = ht * (g.vv + g.vf + g.vs + g.vb);
    p = cnt % fr;
    x = p % ht;
    y = p / ht;
    e_fs = jst && (cnt > 0) && (p == 0);
    e_hs = 1'b1; e_vs = 1'b1; e_bl = 1'b0; rgb = 24'h0;
    m = cnt - g.pd;
    if (m >= 0) begin
      px = (m % fr) % ht;
      py = (m % fr) / ht;
      e_hs = !(px >= g.hv + g.hf && px < g.hv + g.hf + g.hs);
      e_vs = !(py >= g.vv + g.vf && py < g.vv + g.vf + g.vs);
      e_bl = (px < g.hv) && (py < g.vv);
    end
    k = cnt - 1 - g.pd;
    if (k >= 0) begin
      px = (k % fr) % ht;
      py = (k % fr) / ht;
      if (px < g.hv && py < g.vv) rgb = colour(px, py, sd);
    end
    return {1'b0, 10'(x), 10'(y), e_fs, e_hs, e_vs, e_bl, rgb};
  endfunction

  function automatic logic [146:0] exp_all();
    return {model(G1, n, just, seed), model(G2, n, just, seed), model(G3, n, just, seed)};
  endfunction

  task automatic tick(input bit en, input bit rst);
    pixel_en = en;
    Reset    = rst;
    @(posedge Clk);
    #1;
    clk_cnt++;
    if (rst) begin
      n = 0; just = 1'b0;
    end else if (en) begin
      n++; just = 1'b1;
    end else begin
      just = 1'b0;
    end
    mp[0] = mapper_val(G1, n, seed);
    mp[1] = mapper_val(G2, n, seed);
    mp[2] = mapper_val(G3, n, seed);
  endtask

  task automatic seek(input geo_t g, input int tx, input int ty, output bit ok);
    int ht, fr, guard;
    ht = g.hv + g.hf + g.hs + g.hb;
    fr = ht * (g.vv + g.vf + g.vs + g.vb);
    ok = 1'b0;
    guard = 0;
    while (!ok && guard < 2 * fr) begin
      if ((n % fr) % ht == tx && (n % fr) / ht == ty) ok = 1'b1;
      else begin
        tick(1'b1, 1'b0);
        guard++;
      end
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'($urandom_range(0, 1)), 1'b1);
      checks++;
      if (obs_all !== exp_all()) begin
        errors++;
        $display("FAIL reset_state i=%0d got=%h exp=%h", i, obs_all, exp_all());
      end
    end
  endtask

  task automatic test_sync_counts();
    int hs_low = 0, vs_low = 0, gap;
    int fs_t[$];
    for (int i = 0; i < 4 * FR1; i++) begin
      tick(i % 2 == 1, 1'b0);
      checks++;
      if (obs_all !== exp_all()) begin
        errors++;
        $display("FAIL half_rate n=%0d got=%h exp=%h", n, obs_all, exp_all());
      end
      if (just && !hs[0]) hs_low++;
      if (just && !vs[0]) vs_low++;
      if (fs[0]) fs_t.push_back(clk_cnt);
    end
    checks++;
    if (hs_low !== 2 * G1.hs * VT1) begin
      errors++;
      $display("FAIL hs_low_strobes got=%0d exp=%0d", hs_low, 2 * G1.hs * VT1);
    end
    checks++;
    if (vs_low !== 2 * G1.vs * HT1) begin
      errors++;
      $display("FAIL vs_low_strobes got=%0d exp=%0d", vs_low, 2 * G1.vs * HT1);
    end
    checks++;
    if (fs_t.size() !== 2) begin
      errors++;
      $display("FAIL frame_start_count got=%0d exp=2", fs_t.size());
    end
    gap = (fs_t.size() == 2) ? fs_t[1] - fs_t[0] : -1;
    checks++;
    if (gap !== 2 * FR1) begin
      errors++;
      $display("FAIL frame_start_gap got=%0d exp=%0d", gap, 2 * FR1);
    end
  endtask

  task automatic test_colour();
    for (int i = 0; i < 3 * FR1; i++) begin
      tick($urandom_range(0, 3) != 0, 1'b0);
      checks++;
      if (obs_all !== exp_all()) begin
        errors++;
        $display("FAIL colour n=%0d got=%h exp=%h", n, obs_all, exp_all());
      end
    end
  endtask

  task automatic test_freeze();
    bit ok;
    seek(G1, 10, 2, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL freeze_seek got=%0b exp=1", ok); end
    for (int i = 0; i < 50; i++) begin
      tick(1'b0, 1'b0);
      checks++;
      if (obs_all !== exp_all()) begin
        errors++;
        $display("FAIL freeze_hold i=%0d got=%h exp=%h", i, obs_all, exp_all());
      end
    end
    tick(1'b1, 1'b0);
    checks++;
    if (dx[0] !== 10'd11 || obs_all !== exp_all()) begin
      errors++;
      $display("FAIL freeze_resume drawx=%0d exp=11 got=%h exp=%h", dx[0], obs_all, exp_all());
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    seek(G1, HT1 - 4, 4, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midreset_seek got=%0b exp=1", ok); end
    tick(1'($urandom_range(0, 1)), 1'b1);
    checks++;
    if ({dx[0], dy[0], hs[0], bl[0]} !== {10'd0, 10'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midreset_state got=%h exp=%h", {dx[0], dy[0], hs[0], bl[0]}, 22'h2);
    end
    for (int i = 0; i < 3 * HT1; i++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (obs_all !== exp_all()) begin
        errors++;
        $display("FAIL midreset_release n=%0d got=%h exp=%h", n, obs_all, exp_all());
      end
    end
  endtask

  task automatic test_corner();
    bit ok;
    seek(G1, HT1 - 1, VT1 - 1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL corner_seek got=%0b exp=1", ok); end
    tick(1'b1, 1'b0);
    checks++;
    if ({dx[0], dy[0], fs[0]} !== {10'd0, 10'd0, 1'b1}) begin
      errors++;
      $display("FAIL corner_wrap got=%h exp=%h", {dx[0], dy[0], fs[0]}, 21'h1);
    end
    tick(1'b0, 1'b0);
    checks++;
    if (fs[0] !== 1'b0) begin errors++; $display("FAIL corner_pulse_end got=%b exp=0", fs[0]); end
    tick(1'b1, 1'b0);
    checks++;
    if ({dx[0], fs[0]} !== {10'd1, 1'b0}) begin
      errors++;
      $display("FAIL corner_next got=%h exp=%h", {dx[0], fs[0]}, 11'h2);
    end
  endtask

  task automatic test_pipe2();
    bit ok;
    seek(G2, 0, 1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL pipe2_seek got=%0b exp=1", ok); end
    tick(1'b1, 1'b0);
    checks++;
    if ({bl[1], bl[0]} !== 2'b01) begin
      errors++;
      $display("FAIL pipe2_step1 got=%b exp=01", {bl[1], bl[0]});
    end
    tick(1'b1, 1'b0);
    checks++;
    if (bl[1] !== 1'b1) begin errors++; $display("FAIL pipe2_step2 got=%b exp=1", bl[1]); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < FR1 + 50; i++) begin
      tick(1'b1, 1'b0);
      checks++;
      if (obs_all !== exp_all()) begin
        errors++;
        $display("FAIL back_to_back n=%0d got=%h exp=%h", n, obs_all, exp_all());
      end
    end
  endtask

  initial begin
    seed  = 8'($urandom());
    mp[0] = 24'h0;
    mp[1] = 24'h0;
    mp[2] = 24'h0;
    test_reset();
    test_sync_counts();
    test_colour();
    test_freeze();
    test_mid_reset();
    test_corner();
    test_pipe2();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
